// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, address-width helper and default word type for the register file
package regfile_pkg;

  localparam int RF_DEF_WIDTH = 32;
  localparam int RF_DEF_DEPTH = 32;
  localparam int RF_ZERO_IDX  = 0;
  localparam int RF_SP_IDX    = 2;

  typedef logic [RF_DEF_WIDTH-1:0] rf_word_t;

  // Address width never drops below 1, so tiny files still get a real address bus.
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rf_word.sv
// rtl/rf_word.sv - one register-file entry with asynchronous active-high reset to RST_VAL
module rf_word
  import regfile_pkg::*;
#(
  parameter int               WIDTH   = RF_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - DEPTH x WIDTH register file, one sync write port, NUM_RD combinational reads
// Optional write-first bypass on the read ports: define RF_WRITE_BYPASS_EN.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int               WIDTH    = RF_DEF_WIDTH,
  parameter int               DEPTH    = RF_DEF_DEPTH,
  parameter int               NUM_RD   = 2,
  parameter int               ZERO_REG = 1,
  parameter int               SP_IDX   = RF_SP_IDX,
  parameter logic [WIDTH-1:0] SP_INIT  = '0,
  localparam int              ADDR_W   = addr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*WIDTH-1:0]  rd_data
);

  // The read array covers the whole address space; slots past DEPTH are constant zero.
  localparam int SLOTS = 1 << ADDR_W;

  logic [WIDTH-1:0] mem [SLOTS];
  logic [DEPTH-1:0] we;

  genvar i, k;

  for (i = 0; i < SLOTS; i++) begin : g_entry
    if (i < DEPTH) begin : g_word
      localparam bit               IS_ZERO = (ZERO_REG != 0) && (i == RF_ZERO_IDX);
      localparam logic [WIDTH-1:0] RST_VAL = (i == SP_IDX) ? SP_INIT : '0;
      logic [WIDTH-1:0] q;

      assign we[i] = wr && (wr_addr == ADDR_W'(i)) && !IS_ZERO;

      rf_word #(
        .WIDTH  (WIDTH),
        .RST_VAL(RST_VAL)
      ) u_word (
        .clk(clk),
        .rst(rst),
        .we (we[i]),
        .d  (wr_data),
        .q  (q)
      );

      assign mem[i] = IS_ZERO ? '0 : q;
    end else begin : g_pad
      assign mem[i] = '0;
    end
  end

`ifdef RF_WRITE_BYPASS_EN
  // A write that hits a real, writable entry is forwarded; discarded writes never bypass.
  logic wr_hit;
  assign wr_hit = (|we) && !rst;
`endif

  for (k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef RF_WRITE_BYPASS_EN
    assign rd_data[k*WIDTH +: WIDTH] = (wr_hit && (ra == wr_addr)) ? wr_data : mem[ra];
`else
    assign rd_data[k*WIDTH +: WIDTH] = mem[ra];
`endif
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// tb/tb_regfile_multiport.sv - directed self-checking bench for regfile_multiport (default, ZERO_REG=0, odd-depth builds)
module tb_regfile_multiport;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic        d_wr;
  logic [4:0]  d_wa;
  logic [31:0] d_wd;
  logic [9:0]  d_ra;
  logic [63:0] d_rd;

  logic        n_wr;
  logic [4:0]  n_wa;
  logic [31:0] n_wd;
  logic [9:0]  n_ra;
  logic [63:0] n_rd;

  logic        o_wr;
  logic [4:0]  o_wa;
  logic [31:0] o_wd;
  logic [14:0] o_ra;
  logic [95:0] o_rd;

  rf_word_t model [32];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pre;

  always #5 clk = ~clk;

  regfile_multiport #(.SP_INIT(32'h0000_3FFC)) u_def (
    .clk(clk), .rst(rst), .wr(d_wr), .wr_addr(d_wa), .wr_data(d_wd),
    .rd_addr(d_ra), .rd_data(d_rd)
  );

  regfile_multiport #(.ZERO_REG(0)) u_nz (
    .clk(clk), .rst(rst), .wr(n_wr), .wr_addr(n_wa), .wr_data(n_wd),
    .rd_addr(n_ra), .rd_data(n_rd)
  );

  regfile_multiport #(.DEPTH(24), .NUM_RD(3)) u_odd (
    .clk(clk), .rst(rst), .wr(o_wr), .wr_addr(o_wa), .wr_data(o_wd),
    .rd_addr(o_ra), .rd_data(o_rd)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [REGFILE TB] mismatch %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = '0;
    model[2] = 32'h0000_3FFC;
  endtask

  task automatic def_write(input int a, input logic [31:0] d);
    @(negedge clk);
    d_wr = 1'b1; d_wa = 5'(a); d_wd = d;
    @(posedge clk);
    #1;
    d_wr = 1'b0;
    if (a != 0) model[a] = d;
  endtask

  task automatic def_read2(input int a0, input int a1);
    @(negedge clk);
    d_ra = {5'(a1), 5'(a0)};
    #1;
  endtask

  task automatic def_verify(input string tag);
    for (int i = 0; i < 32; i++) begin
      def_read2(i, 31 - i);
      check($sformatf("%s p0 addr %0d", tag, i), d_rd[31:0], model[i]);
      check($sformatf("%s p1 addr %0d", tag, 31 - i), d_rd[63:32], model[31 - i]);
    end
  endtask

  task automatic nz_write(input int a, input logic [31:0] d);
    @(negedge clk);
    n_wr = 1'b1; n_wa = 5'(a); n_wd = d;
    @(posedge clk);
    #1;
    n_wr = 1'b0;
  endtask

  task automatic odd_write(input int a, input logic [31:0] d);
    @(negedge clk);
    o_wr = 1'b1; o_wa = 5'(a); o_wd = d;
    @(posedge clk);
    #1;
    o_wr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b0;
    d_wr = 1'b0; d_wa = '0; d_wd = '0; d_ra = '0;
    n_wr = 1'b0; n_wa = '0; n_wd = '0; n_ra = '0;
    o_wr = 1'b0; o_wa = '0; o_wd = '0; o_ra = '0;
    model_reset();

    // 1: reset values, checked while rst is held and after release
    #2 rst = 1'b1;
    d_ra = {5'd2, 5'd0};
    #1;
    check("in-reset addr 0", d_rd[31:0], 32'h0);
    check("in-reset addr 2 sp", d_rd[63:32], 32'h0000_3FFC);
    @(negedge clk);
    rst = 1'b0;
    def_verify("reset");
    n_ra = {5'd2, 5'd0};
    #1;
    check("nz reset addr 0", n_rd[31:0], 32'h0);
    check("nz reset addr 2", n_rd[63:32], 32'h0);

    // 2: single write seen on both ports, then full sweep
    def_write(5, 32'hDEAD_BEEF);
    def_read2(5, 5);
    check("wr5 p0", d_rd[31:0], 32'hDEAD_BEEF);
    check("wr5 p1", d_rd[63:32], 32'hDEAD_BEEF);
    for (int i = 0; i < 32; i++) def_write(i, 32'(4 * i));
    def_verify("sweep");

    // 3: zero register discards writes; ZERO_REG=0 keeps them
    def_write(0, 32'hFFFF_FFFF);
    def_read2(0, 0);
    check("zero p0", d_rd[31:0], 32'h0);
    check("zero p1", d_rd[63:32], 32'h0);
    nz_write(0, 32'hFFFF_FFFF);
    @(negedge clk);
    n_ra = {5'd0, 5'd0};
    #1;
    check("nz addr0 p0", n_rd[31:0], 32'hFFFF_FFFF);
    check("nz addr0 p1", n_rd[63:32], 32'hFFFF_FFFF);

    // 4: same-cycle read of the entry being written
    def_write(7, 32'h11);
`ifdef RF_WRITE_BYPASS_EN
    exp_pre = 32'h22;
`else
    exp_pre = 32'h11;
`endif
    @(negedge clk);
    d_wr = 1'b1; d_wa = 5'd7; d_wd = 32'h22; d_ra = {5'd0, 5'd7};
    #1;
    check("hazard pre-edge", d_rd[31:0], exp_pre);
    @(posedge clk);
    #1;
    d_wr = 1'b0;
    model[7] = 32'h22;
    check("hazard post-edge", d_rd[31:0], 32'h22);
    @(negedge clk);
    d_wr = 1'b1; d_wa = 5'd0; d_wd = 32'hFFFF_FFFF; d_ra = {5'd0, 5'd0};
    #1;
    check("zero no bypass", d_rd[31:0], 32'h0);
    @(posedge clk);
    #1;
    d_wr = 1'b0;
    check("zero after edge", d_rd[63:32], 32'h0);

    // 6: odd depth, out-of-range write/read, three simultaneous ports
    @(negedge clk);
    o_wr = 1'b1; o_wa = 5'd30; o_wd = 32'h77; o_ra = {5'd30, 5'd30, 5'd30};
    #1;
    check("odd oor no bypass", o_rd[95:64], 32'h0);
    @(posedge clk);
    #1;
    o_wr = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      o_ra = {5'd30, 5'd24, 5'(i)};
      #1;
      check($sformatf("odd oor entry %0d", i), o_rd[31:0], 32'h0);
    end
    check("odd addr 24", o_rd[63:32], 32'h0);
    check("odd addr 30", o_rd[95:64], 32'h0);
    odd_write(1, 32'h101);
    odd_write(23, 32'h2323);
    @(negedge clk);
    o_ra = {5'd30, 5'd23, 5'd1};
    #1;
    check("odd p0 addr 1", o_rd[31:0], 32'h101);
    check("odd p1 addr 23", o_rd[63:32], 32'h2323);
    check("odd p2 addr 30", o_rd[95:64], 32'h0);

    // 5: async reset in the middle of a write
    def_write(9, 32'hA5);
    def_read2(9, 9);
    check("pre-rst addr 9", d_rd[31:0], 32'hA5);
    @(negedge clk);
    d_wr = 1'b1; d_wa = 5'd9; d_wd = 32'h5A; rst = 1'b1;
    #1;
    d_ra = {5'd2, 5'd9};
    #1;
    check("async rst addr 9", d_rd[31:0], 32'h0);
    check("async rst addr 2", d_rd[63:32], 32'h0000_3FFC);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; d_wr = 1'b0;
    #1;
    check("post-rst addr 9", d_rd[31:0], 32'h0);

    // rst released shortly before an edge: that edge writes normally
    @(negedge clk);
    rst = 1'b1; d_wr = 1'b1; d_wa = 5'd9; d_wd = 32'h5A;
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    d_wr = 1'b0;
    model[9] = 32'h5A;
    check("late release addr 9", d_rd[31:0], 32'h5A);
    def_verify("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
